// File: rtl/hack_pc_if.sv
// hack_pc_if: fetch-side bus between the Hack CPU datapath and its program counter.
interface hack_pc_if;
  logic [15:0] a_in;
  logic [15:0] instr;
  logic        zr;
  logic        ng;
  logic        stall;
  logic [15:0] pc;
  logic        jump_taken;
  logic        halted;
  modport master (
    output a_in, instr, zr, ng, stall,
    input  pc, jump_taken, halted
  );
  modport slave (
    input  a_in, instr, zr, ng, stall,
    output pc, jump_taken, halted
  );
endinterface

// File: rtl/hack_pc.sv
// hack_pc: Hack program counter with jump decode, stall hold and optional self-loop halt.
module hack_pc #(
  parameter bit HALT_EN = 1'b1
) (
  input logic     clk,
  input logic     reset,
  hack_pc_if.slave bus
);
  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        jt_q, jt_d;
  logic        jmp, self_loop;
  assign jmp = bus.instr[15] & ((bus.instr[2] & bus.ng) | (bus.instr[1] & bus.zr) |
                                (bus.instr[0] & ~bus.ng & ~bus.zr));
  assign self_loop = HALT_EN && (bus.a_in == pc_q);
  // HOLD with stall low behaves exactly like RUN, so both share one path
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    jt_d    = 1'b0;
    if (state_q != HALT) begin
      if (bus.stall) state_d = HOLD;
      else begin
        jt_d    = jmp;
        state_d = (jmp && self_loop) ? HALT : RUN;
        pc_d    = jmp ? bus.a_in : pc_q + 16'd1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= 16'h0000;
      jt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      jt_q    <= jt_d;
    end
  end
  assign bus.pc         = pc_q;
  assign bus.jump_taken = jt_q;
  assign bus.halted     = (state_q == HALT);
endmodule

// File: tb/tb_hack_pc.sv
// tb_hack_pc: vector table plus hand sequences, scoreboarded against HALT_EN=1 and HALT_EN=0 instances.
module tb_hack_pc;
  logic clk = 1'b0;
  logic reset = 1'b0;
  hack_pc_if b1();
  hack_pc_if b0();
  hack_pc #(.HALT_EN(1'b1)) dut  (.clk(clk), .reset(reset), .bus(b1));
  hack_pc #(.HALT_EN(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  assign b0.a_in  = b1.a_in;
  assign b0.instr = b1.instr;
  assign b0.zr    = b1.zr;
  assign b0.ng    = b1.ng;
  assign b0.stall = b1.stall;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, ins;
    logic        zr, ng, st;
    logic [15:0] pc;
    logic        jt, h;
  } vec_t;
  typedef struct {
    string       tag;
    bit          d0;
    logic [15:0] pc;
    logic        jt, h;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int nvec = 0;
  int nerr = 0;

  function automatic vec_t v(logic [15:0] a, logic [15:0] ins, logic zr, logic ng, logic st,
                             logic [15:0] pc, logic jt, logic h);
    vec_t r;
    r.a = a; r.ins = ins; r.zr = zr; r.ng = ng; r.st = st; r.pc = pc; r.jt = jt; r.h = h;
    return r;
  endfunction

  task automatic drive(logic [15:0] a, logic [15:0] ins, logic zr, logic ng, logic st);
    b1.a_in = a; b1.instr = ins; b1.zr = zr; b1.ng = ng; b1.stall = st;
  endtask

  task automatic push(string tag, bit d0, logic [15:0] pc, logic jt, logic h);
    exp_t e;
    e.tag = tag; e.d0 = d0; e.pc = pc; e.jt = jt; e.h = h;
    sbq.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    logic [15:0] p;
    logic jt, h;
    while (sbq.size() > 0) begin
      e  = sbq.pop_front();
      p  = e.d0 ? b0.pc : b1.pc;
      jt = e.d0 ? b0.jump_taken : b1.jump_taken;
      h  = e.d0 ? b0.halted : b1.halted;
      nvec++;
      if (p !== e.pc || jt !== e.jt || h !== e.h) begin
        nerr++;
        $display("FAIL %s%s: got pc=%h jt=%b halted=%b, want pc=%h jt=%b halted=%b",
                 e.tag, e.d0 ? "/halt_en0" : "", p, jt, h, e.pc, e.jt, e.h);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
    @(negedge clk);
  endtask

  initial begin
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    // reset/count, unconditional jump
    for (int i = 1; i <= 5; i++) tbl.push_back(v(16'h0000, 16'h0000, 0, 0, 0, 16'(i), 0, 0));
    tbl.push_back(v(16'h0100, 16'hE307, 0, 0, 0, 16'h0100, 1, 0));
    tbl.push_back(v(16'h0100, 16'h0000, 0, 0, 0, 16'h0101, 0, 0));
    // conditional sweep from 0x0010
    tbl.push_back(v(16'h0010, 16'hE307, 0, 0, 0, 16'h0010, 1, 0));
    tbl.push_back(v(16'h0040, 16'hE301, 0, 0, 0, 16'h0040, 1, 0));
    tbl.push_back(v(16'h0010, 16'hE307, 0, 0, 0, 16'h0010, 1, 0));
    tbl.push_back(v(16'h0040, 16'hE301, 0, 1, 0, 16'h0011, 0, 0));
    tbl.push_back(v(16'h0010, 16'hE307, 0, 0, 0, 16'h0010, 1, 0));
    tbl.push_back(v(16'h0040, 16'hE302, 1, 0, 0, 16'h0040, 1, 0));
    tbl.push_back(v(16'h0010, 16'hE307, 0, 0, 0, 16'h0010, 1, 0));
    tbl.push_back(v(16'h0040, 16'hE304, 0, 1, 0, 16'h0040, 1, 0));
    tbl.push_back(v(16'h0010, 16'hE307, 0, 0, 0, 16'h0010, 1, 0));
    tbl.push_back(v(16'h0040, 16'hE305, 1, 0, 0, 16'h0011, 0, 0));
    tbl.push_back(v(16'h0040, 16'h0007, 1, 1, 0, 16'h0012, 0, 0));
    tbl.push_back(v(16'h0040, 16'hE303, 1, 1, 0, 16'h0040, 1, 0));
    tbl.push_back(v(16'h0080, 16'hE301, 1, 1, 0, 16'h0041, 0, 0));
    // stall holds pc, jump applies on the edge stall drops
    tbl.push_back(v(16'h0020, 16'hE307, 0, 0, 0, 16'h0020, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(16'h0030, 16'hE307, 0, 0, 1, 16'h0020, 0, 0));
    tbl.push_back(v(16'h0030, 16'hE307, 0, 0, 0, 16'h0030, 1, 0));
    tbl.push_back(v(16'h0030, 16'h0000, 0, 0, 0, 16'h0031, 0, 0));
    // wrap-around
    tbl.push_back(v(16'hFFFE, 16'hE307, 0, 0, 0, 16'hFFFE, 1, 0));
    tbl.push_back(v(16'h0000, 16'h0000, 0, 0, 0, 16'hFFFF, 0, 0));
    tbl.push_back(v(16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(v(16'hFFFF, 16'hE307, 0, 0, 0, 16'hFFFF, 1, 0));
    tbl.push_back(v(16'hFFFF, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(v(16'h0050, 16'hE307, 0, 0, 0, 16'h0050, 1, 0));

    #1 reset = 1'b1;
    #1;
    push("reset", 0, 16'h0000, 0, 0);
    push("reset", 1, 16'h0000, 0, 0);
    check_now();
    @(negedge clk);
    reset = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].ins, tbl[i].zr, tbl[i].ng, tbl[i].st);
      push($sformatf("vec%0d", i), 0, tbl[i].pc, tbl[i].jt, tbl[i].h);
      push($sformatf("vec%0d", i), 1, tbl[i].pc, tbl[i].jt, tbl[i].h);
      tick();
    end

    // self-loop at 0x0050 halts only when enabled
    drive(16'h0050, 16'hE307, 0, 0, 0);
    push("halt_entry", 0, 16'h0050, 1, 1);
    push("halt_entry", 1, 16'h0050, 1, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      push($sformatf("halt_hold%0d", i), 0, 16'h0050, 0, 1);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    push("halt_reset", 0, 16'h0000, 0, 0);
    push("halt_reset", 1, 16'h0000, 0, 0);
    check_now();
    @(negedge clk);
    reset = 1'b0;
    drive(16'h0000, 16'h0000, 0, 0, 0);
    push("post_reset", 0, 16'h0001, 0, 0);
    push("post_reset", 1, 16'h0001, 0, 0);
    tick();

    // reset in HOLD discards the pending jump
    drive(16'h1234, 16'hE307, 0, 0, 1);
    push("hold_a", 0, 16'h0001, 0, 0);
    tick();
    push("hold_b", 0, 16'h0001, 0, 0);
    tick();
    #2 reset = 1'b1;
    #1;
    push("hold_reset", 0, 16'h0000, 0, 0);
    check_now();
    @(negedge clk);
    reset = 1'b0;
    drive(16'h1234, 16'h0000, 0, 0, 0);
    push("hold_post", 0, 16'h0001, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/hack_pc.md
HACK_PC -- requirements
Module: hack_pc

Interface
REQ-001 Parameter: HALT_EN, 1, when 1 self-loop halt detection is enabled; when 0 the HALT state is unreachable.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 reset  input  1  reset, asynchronous and active-high.
REQ-004 a_in  input  16  jump target, taken directly from the A-register reg16 out.
REQ-005 instr  input  16  current instruction word; bit15=1 marks a C-instruction, bits[2:0]=j1,j2,j3.
REQ-006 zr  input  1  ALU zero flag for the current instruction.
REQ-007 ng  input  1  ALU negative flag for the current instruction.
REQ-008 stall  input  1  hold request from memory/fetch; 1 freezes pc.
REQ-009 pc  output  16  registered instruction ROM address.
REQ-010 jump_taken  output  1  registered; 1 for one cycle after a cycle that loaded pc from a_in.
REQ-011 halted  output  1  registered; 1 while in HALT state.

Function
REQ-012 jmp = instr[15] & ((instr[2]&ng) | (instr[1]&zr) | (instr[0]&~ng&~zr)), evaluated combinationally each cycle.
REQ-013 A-instructions (instr[15]=0) never jump, regardless of bits[2:0].
REQ-014 State machine states: RUN, HOLD, HALT; reset state RUN.
REQ-015 RUN, stall=1: pc holds, jump_taken<=0, next state HOLD; jump condition is ignored that cycle.
REQ-016 RUN, stall=0, jmp=1: pc<=a_in, jump_taken<=1, next state RUN, except as REQ-018.
REQ-017 RUN, stall=0, jmp=0: pc<=pc+1 modulo 2^16, jump_taken<=0.
REQ-018 RUN, stall=0, jmp=1, HALT_EN=1, a_in==pc: pc holds, jump_taken<=1, halted<=1, next state HALT.
REQ-019 HOLD, stall=1: pc holds, jump_taken<=0, stay HOLD.
REQ-020 HOLD, stall=0: evaluate exactly as RUN with stall=0 (REQ-016..018) in that same cycle; next state per those rules.
REQ-021 HALT: pc holds, halted=1, jump_taken<=0; stall, instr, flags ignored; exit only via reset.
REQ-022 Wrap-around: pc=0xFFFF with increment gives pc=0x0000; no flag, no halt.
REQ-023 Jump to 0xFFFF is a normal jump; next increment wraps to 0x0000.
REQ-024 Priority per cycle: reset > HALT > stall > jump > increment.
REQ-025 Latency: pc updates on the rising edge after inputs are presented; no combinational path from any input to pc, jump_taken, or halted.
REQ-026 zr and ng both 1 is treated as given; with j1=j2=1, jmp=1. The gt term is 0.

Reset
REQ-027 reset=1 forces immediately, without a clock edge: pc=0x0000, jump_taken=0, halted=0, state RUN.
REQ-028 Reset asserted mid-HOLD or mid-HALT has the same effect as REQ-027; any pending stall or jump is discarded.
REQ-029 On the first rising edge after reset deasserts, normal RUN evaluation applies; pc becomes 0x0001 if no jump occurs.

Verification
REQ-030 Reset, then 5 cycles with instr=0x0000, stall=0 -> pc 0x0001..0x0005; jump_taken=0; halted=0.
REQ-031 pc=0x0005, instr=0xE307 (JMP), a_in=0x0100 -> next pc=0x0100, jump_taken=1 for one cycle; following cycle with instr=0x0000 -> pc=0x0101.
REQ-032 Conditional sweep at pc=0x0010, a_in=0x0040:
- JGT (bits=001) with zr=0, ng=0 -> pc=0x0040.
- JGT with ng=1 -> pc=0x0011.
- JEQ (010) with zr=1 -> pc=0x0040.
- JLT (100) with ng=1 -> pc=0x0040.
- JNE (101) with zr=1 -> pc=0x0011.
REQ-033 stall=1 for 3 cycles at pc=0x0020 -> pc holds 0x0020 while a JMP is presented; after stall drops with JMP still presented and a_in=0x0030 -> pc=0x0030 on the same edge.
REQ-034 pc=0x0050, instr=0xE307, a_in=0x0050 -> halted=1, pc stays 0x0050 for 10 cycles regardless of inputs; async reset pulse mid-cycle -> pc=0x0000, halted=0 before the next edge. With HALT_EN=0, the same stimulus gives pc=0x0050, jump_taken=1, halted=0.
REQ-035 Load pc=0xFFFE via jump, then two increments -> pc 0xFFFF then 0x0000, halted=0.
